// File: rtl/fifo_axis_reader.sv
// fifo_axis_reader: drains a synchronous FIFO read port (data one cycle after rd_en) and
// presents the words as an AXI-Stream master through a two-entry head/skid buffer.
// Optional feature: define FIFO_AXIS_READER_TLAST_EN to generate m_axis_tlast every
// beats_per_packet beats; otherwise m_axis_tlast is tied low and no counter is built.

module fifo_axis_reader #(
   parameter int unsigned num_data_bits    = 32,
   parameter int unsigned beats_per_packet = 16
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     fifo_empty,
   output logic                     fifo_rd_en,
   input  logic [num_data_bits-1:0] fifo_out,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic [num_data_bits-1:0] m_axis_tdata,
   output logic                     m_axis_tlast
);

   if (beats_per_packet < 1) begin : g_bad_bpp
      $error("beats_per_packet must be at least 1");
   end

   // Head entry: this is what the stream sees.
   logic [num_data_bits-1:0] head_data_q, head_data_d;
   logic                     head_last_q, head_last_d;
   logic                     head_valid_q, head_valid_d;

   // Skid entry: absorbs the word that was already in flight when the head stalled.
   logic [num_data_bits-1:0] skid_data_q, skid_data_d;
   logic                     skid_last_q, skid_last_d;
   logic                     skid_valid_q, skid_valid_d;

   // A read was issued last cycle, so fifo_out carries a word this cycle.
   logic                     inflight_q, inflight_d;

   logic                     pop;
   logic [1:0]               count;
   logic [2:0]               occupancy;
   logic                     capture_last;

   // Handshake and read-issue decision; rd_en looks at this cycle's pop so a full
   // buffer that is being drained can still keep the read pipeline busy.
   always_comb begin
      pop        = head_valid_q & m_axis_tready;
      count      = {1'b0, head_valid_q} + {1'b0, skid_valid_q};
      // pop implies head_valid_q, so this never underflows
      occupancy  = {1'b0, count} + {2'b00, inflight_q} - {2'b00, pop};
      fifo_rd_en = reset_n & ~fifo_empty & (occupancy < 3'd2);
   end

`ifdef FIFO_AXIS_READER_TLAST_EN
   localparam int unsigned cnt_w = (beats_per_packet > 1) ? $clog2(beats_per_packet) : 1;
   localparam int unsigned idx_w = cnt_w + 2;
   localparam logic [cnt_w-1:0] cnt_max = cnt_w'(beats_per_packet - 1);
   localparam logic [idx_w-1:0] bpp_ext = idx_w'(beats_per_packet);
   localparam logic [idx_w-1:0] last_idx = idx_w'(beats_per_packet - 1);

   // Packet position of the beat currently at the head (or next to be presented).
   logic [cnt_w-1:0] beat_cnt_q, beat_cnt_d;
   logic [idx_w-1:0] capture_idx;

   // Beat counter advances on every accepted beat and wraps after the last one.
   always_comb begin
      beat_cnt_d = beat_cnt_q;
      if (pop) begin
         beat_cnt_d = (beat_cnt_q == cnt_max) ? '0 : beat_cnt_q + 1'b1;
      end
   end

   // A captured word sits behind every entry already buffered, so its packet position is
   // the head position plus the current entry count, reduced modulo the packet length.
   always_comb begin
      capture_idx = {2'b00, beat_cnt_q} + {{cnt_w{1'b0}}, count};
      if (capture_idx >= bpp_ext) begin
         capture_idx = capture_idx - bpp_ext;
      end
      // count can reach 2, so a packet length of 1 may need a second reduction
      if (capture_idx >= bpp_ext) begin
         capture_idx = capture_idx - bpp_ext;
      end
      capture_last = (capture_idx == last_idx);
   end

   // Beat counter register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         beat_cnt_q <= '0;
      end else begin
         beat_cnt_q <= beat_cnt_d;
      end
   end
`else
   // Without packet framing every beat is a non-last beat.
   always_comb begin
      capture_last = 1'b0;
   end
`endif

   // Buffer next-state: pop shifts skid into head, then the in-flight word lands in the
   // first free slot in stream order.
   always_comb begin
      head_data_d  = head_data_q;
      head_last_d  = head_last_q;
      head_valid_d = head_valid_q;
      skid_data_d  = skid_data_q;
      skid_last_d  = skid_last_q;
      skid_valid_d = skid_valid_q;
      inflight_d   = fifo_rd_en;

      if (pop) begin
         if (skid_valid_q) begin
            head_data_d  = skid_data_q;
            head_last_d  = skid_last_q;
            skid_valid_d = 1'b0;
         end else begin
            head_valid_d = 1'b0;
         end
      end

      if (inflight_q) begin
         if (!head_valid_q || (pop && !skid_valid_q)) begin
            head_data_d  = fifo_out;
            head_last_d  = capture_last;
            head_valid_d = 1'b1;
         end else begin
            skid_data_d  = fifo_out;
            skid_last_d  = capture_last;
            skid_valid_d = 1'b1;
         end
      end
   end

   // Buffer and in-flight registers; reset discards any read still in flight.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         head_data_q  <= '0;
         head_last_q  <= 1'b0;
         head_valid_q <= 1'b0;
         skid_data_q  <= '0;
         skid_last_q  <= 1'b0;
         skid_valid_q <= 1'b0;
         inflight_q   <= 1'b0;
      end else begin
         head_data_q  <= head_data_d;
         head_last_q  <= head_last_d;
         head_valid_q <= head_valid_d;
         skid_data_q  <= skid_data_d;
         skid_last_q  <= skid_last_d;
         skid_valid_q <= skid_valid_d;
         inflight_q   <= inflight_d;
      end
   end

   // Stream outputs come straight from the head register.
   always_comb begin
      m_axis_tvalid = head_valid_q;
      m_axis_tdata  = head_data_q;
      m_axis_tlast  = head_last_q;
   end

   // Reads are never requested from an empty FIFO.
   a_no_read_when_empty : assert property (
      @(posedge clk) disable iff (!reset_n) fifo_rd_en |-> !fifo_empty);

   // A stalled beat stays presented with unchanged payload.
   a_stall_stable : assert property (
      @(posedge clk) disable iff (!reset_n)
      (m_axis_tvalid && !m_axis_tready) |=>
      (m_axis_tvalid && $stable(m_axis_tdata) && $stable(m_axis_tlast)));

   // An arriving word always finds a free slot.
   a_no_overflow : assert property (
      @(posedge clk) disable iff (!reset_n)
      inflight_q |-> !(head_valid_q && skid_valid_q && !pop));

   // The skid entry is only ever occupied behind a valid head.
   a_skid_behind_head : assert property (
      @(posedge clk) disable iff (!reset_n) skid_valid_q |-> head_valid_q);

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Bench for fifo_axis_reader: a behavioural FIFO feeds the DUT, and a scoreboard compares
// each accepted beat with the words written (order, stall stability, packet framing).
module tb_fifo_axis_reader;

   localparam int unsigned Dw  = 32;
   localparam int unsigned Bpp = 4;
`ifdef FIFO_AXIS_READER_TLAST_EN
   localparam bit tlast_en = 1'b1;
`else
   localparam bit tlast_en = 1'b0;
`endif

   logic          clk;
   logic          reset_n;
   logic          fifo_empty;
   logic          fifo_rd_en;
   logic [Dw-1:0] fifo_out;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic [Dw-1:0] m_axis_tdata;
   logic          m_axis_tlast;

   logic          wr_en;
   logic [Dw-1:0] wr_data;
   logic [Dw-1:0] fifo_q [$];

   // scoreboard: driver appends to sent[], monitor consumes in order
   logic [Dw-1:0] sent [0:2047];
   int            n_sent;
   int            n_rcvd;
   int unsigned   beat_idx;
   int            rd_cnt;
   int            pop_cnt;
   int            last_cnt;
   int            n_cmp;
   int            n_err;
   logic          stall_prev;
   logic [Dw-1:0] stall_data;
   logic          stall_last;
   logic [Dw-1:0] first_word;
   int            base;

   fifo_axis_reader #(
      .num_data_bits    (Dw),
      .beats_per_packet (Bpp)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .fifo_empty    (fifo_empty),
      .fifo_rd_en    (fifo_rd_en),
      .fifo_out      (fifo_out),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tlast  (m_axis_tlast)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      if (obs !== exp) begin
         n_err = n_err + 1;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Behavioural synchronous FIFO: read data appears the cycle after rd_en.
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         fifo_q.delete();
         fifo_out   <= '0;
         fifo_empty <= 1'b1;
      end else begin
         if (fifo_rd_en && fifo_q.size() > 0) fifo_out <= fifo_q.pop_front();
         if (wr_en) fifo_q.push_back(wr_data);
         fifo_empty <= (fifo_q.size() == 0);
      end
   end

   // Monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!reset_n) begin
         n_rcvd     = n_sent;
         beat_idx   = 0;
         stall_prev = 1'b0;
      end else begin
         if (fifo_rd_en) begin
            chk("rd_en_while_empty", 32'(fifo_empty), 32'(0));
            rd_cnt = rd_cnt + 1;
         end
         if (stall_prev) begin
            chk("stall_valid", 32'(m_axis_tvalid), 32'(1));
            chk("stall_data", m_axis_tdata, stall_data);
            chk("stall_last", 32'(m_axis_tlast), 32'(stall_last));
         end
         if (m_axis_tvalid && m_axis_tready) begin
            chk("beat_expected", 32'(n_rcvd < n_sent), 32'(1));
            if (n_rcvd < n_sent) begin
               chk("beat_data", m_axis_tdata, sent[n_rcvd[10:0]]);
               chk("beat_last", 32'(m_axis_tlast),
                   32'(tlast_en && ((beat_idx % Bpp) == (Bpp - 1))));
               n_rcvd = n_rcvd + 1;
            end
            beat_idx = beat_idx + 1;
            pop_cnt  = pop_cnt + 1;
            if (m_axis_tlast) last_cnt = last_cnt + 1;
         end
         stall_prev = m_axis_tvalid && !m_axis_tready;
         stall_data = m_axis_tdata;
         stall_last = m_axis_tlast;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push_word(input logic [Dw-1:0] w);
      wr_en   = 1'b1;
      wr_data = w;
      sent[n_sent[10:0]] = w;
      n_sent  = n_sent + 1;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic wait_drain(input int bound);
      int k;
      k = 0;
      while (n_rcvd != n_sent && k < bound) begin
         m_axis_tready = 1'($urandom_range(0, 1));
         step();
         k = k + 1;
      end
      chk("drain", n_rcvd, n_sent);
   endtask

   // One word into an idle block: tvalid must appear two cycles after fifo_empty falls.
   task automatic latency_probe(input string tag, input logic [Dw-1:0] w);
      m_axis_tready = 1'b1;
      push_word(w);
      chk({tag, "_rd_en"}, 32'(fifo_rd_en), 32'(1));
      chk({tag, "_valid0"}, 32'(m_axis_tvalid), 32'(0));
      step();
      chk({tag, "_valid1"}, 32'(m_axis_tvalid), 32'(0));
      step();
      chk({tag, "_valid2"}, 32'(m_axis_tvalid), 32'(1));
      chk({tag, "_data"}, m_axis_tdata, w);
      step();
      chk({tag, "_valid3"}, 32'(m_axis_tvalid), 32'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
      $fatal(1);
   end

   initial begin
      n_sent = 0; n_rcvd = 0; beat_idx = 0; rd_cnt = 0; pop_cnt = 0; last_cnt = 0;
      n_cmp = 0; n_err = 0; stall_prev = 1'b0; stall_data = '0; stall_last = 1'b0;
      reset_n = 1'b0; wr_en = 1'b0; wr_data = '0; m_axis_tready = 1'b0;
      repeat (3) step();
      chk("reset_tvalid", 32'(m_axis_tvalid), 32'(0));
      chk("reset_tdata", m_axis_tdata, 32'(0));
      chk("reset_tlast", 32'(m_axis_tlast), 32'(0));
      chk("reset_rd_en", 32'(fifo_rd_en), 32'(0));
      #3 reset_n = 1'b1;
      step();

      // Three words back to back with the sink always ready.
      m_axis_tready = 1'b1;
      push_word(32'h11);
      chk("t1_empty_fell", 32'(fifo_empty), 32'(0));
      chk("t1_rd_en", 32'(fifo_rd_en), 32'(1));
      chk("t1_valid_n0", 32'(m_axis_tvalid), 32'(0));
      push_word(32'h22);
      chk("t1_valid_n1", 32'(m_axis_tvalid), 32'(0));
      push_word(32'h33);
      chk("t1_valid_n2", 32'(m_axis_tvalid), 32'(1));
      chk("t1_data0", m_axis_tdata, 32'h11);
      step();
      chk("t1_data1", m_axis_tdata, 32'h22);
      step();
      chk("t1_data2", m_axis_tdata, 32'h33);
      step();
      chk("t1_idle", 32'(m_axis_tvalid), 32'(0));

      // Eight words under a 10-cycle stall, then release.
      m_axis_tready = 1'b0;
      base = rd_cnt;
      first_word = $urandom;
      push_word(first_word);
      for (int i = 1; i < 8; i++) push_word($urandom);
      repeat (10) step();
      chk("t2_reads_in_stall", rd_cnt - base, 2);
      chk("t2_valid_held", 32'(m_axis_tvalid), 32'(1));
      chk("t2_data_held", m_axis_tdata, first_word);
      m_axis_tready = 1'b1;
      base = pop_cnt;
      repeat (8) step();
      chk("t2_back_to_back", pop_cnt - base, 8);
      chk("t2_idle", 32'(m_axis_tvalid), 32'(0));

      // 1000 random words, random write gaps and 50% ready.
      for (int i = 0; i < 1000; i++) begin
         while ($urandom_range(0, 99) >= 70) begin
            m_axis_tready = 1'($urandom_range(0, 1));
            step();
         end
         m_axis_tready = 1'($urandom_range(0, 1));
         push_word($urandom);
      end
      wait_drain(5000);

      // Drained: idle outputs, then a fresh word with two-cycle latency.
      m_axis_tready = 1'b1;
      repeat (3) step();
      chk("t4_idle_valid", 32'(m_axis_tvalid), 32'(0));
      chk("t4_idle_rd_en", 32'(fifo_rd_en), 32'(0));
      latency_probe("t4_resume", $urandom);

      // Reset with a buffered beat, a read in flight and a word still in the FIFO.
      m_axis_tready = 1'b0;
      first_word = $urandom;
      push_word(first_word);
      push_word($urandom);
      push_word($urandom);
      chk("t5_pre_valid", 32'(m_axis_tvalid), 32'(1));
      chk("t5_pre_data", m_axis_tdata, first_word);
      #2 reset_n = 1'b0;
      #1;
      chk("t5_async_tvalid", 32'(m_axis_tvalid), 32'(0));
      chk("t5_async_tdata", m_axis_tdata, 32'(0));
      chk("t5_async_tlast", 32'(m_axis_tlast), 32'(0));
      chk("t5_async_rd_en", 32'(fifo_rd_en), 32'(0));
      repeat (2) step();
      #3 reset_n = 1'b1;
      m_axis_tready = 1'b1;
      base = pop_cnt;
      repeat (10) step();
      chk("t5_no_beats", pop_cnt - base, 0);
      chk("t5_idle_valid", 32'(m_axis_tvalid), 32'(0));
      chk("t5_idle_rd_en", 32'(fifo_rd_en), 32'(0));
      latency_probe("t5_resume", $urandom);

      // Fresh packet alignment, 12 words under random ready.
      #2 reset_n = 1'b0;
      repeat (2) step();
      #3 reset_n = 1'b1;
      step();
      base = last_cnt;
      for (int i = 0; i < 12; i++) begin
         m_axis_tready = 1'($urandom_range(0, 1));
         push_word($urandom);
      end
      wait_drain(500);
      chk("t6_tlast_count", last_cnt - base, tlast_en ? 3 : 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
